// File: rtl/spi_slave_pkg.sv
// Shared types and helpers for the SPI slave shift engine.
//   DEFAULT_DATA_W : default word width
//   PARITY_MAX_W   : widest word even_parity() accepts (callers zero-extend)
//   bit_order_e    : wire bit order
//   cnt_state_e    : bit counter state (IDLE between words, SHIFT mid-word)
package spi_slave_pkg;

  localparam int unsigned DEFAULT_DATA_W = 16;
  localparam int unsigned PARITY_MAX_W   = 64;

  typedef enum logic {
    MSB_FIRST = 1'b0,
    LSB_FIRST = 1'b1
  } bit_order_e;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } cnt_state_e;

  // 1 when the word has an odd number of ones, so word plus this bit is even.
  function automatic logic even_parity(input logic [PARITY_MAX_W-1:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/spi_bit_counter.sv
// Bit position tracker for the SPI slave: wraps at LEN, clears whenever
// chip-select is low, and counts completed words per frame (saturating).
// Ports:
//   clk, rst_n : SPI clock (posedge) and async active-low reset
//   en         : chip select; counter advances only when 1
//   first_c    : current bit position is 0 (combinational)
//   last_c     : current bit position is LEN-1 (combinational)
//   busy       : a word is partially shifted (state register decode)
//   word_cnt   : completed words in the current frame
module spi_bit_counter #(
  parameter int unsigned LEN    = 16,
  parameter int unsigned WCNT_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  output logic              first_c,
  output logic              last_c,
  output logic              busy,
  output logic [WCNT_W-1:0] word_cnt
);
  import spi_slave_pkg::*;

  localparam int unsigned CNT_W = (LEN > 1) ? $clog2(LEN) : 1;

  cnt_state_e        state, state_nxt;
  logic [CNT_W-1:0]  bit_cnt, cnt_nxt;
  logic [WCNT_W-1:0] wcnt_nxt;

  assign first_c = (bit_cnt == '0);
  assign last_c  = (bit_cnt == CNT_W'(LEN - 1));
  assign busy    = (state == SHIFT);

  // State, bit position and word count registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      bit_cnt  <= '0;
      word_cnt <= '0;
    end else begin
      state    <= state_nxt;
      bit_cnt  <= cnt_nxt;
      word_cnt <= wcnt_nxt;
    end
  end

  // Next position: clear on CS low, wrap after the last bit, else advance.
  always_comb begin
    cnt_nxt   = bit_cnt;
    wcnt_nxt  = word_cnt;
    state_nxt = state;
    if (!en) begin
      cnt_nxt  = '0;
      wcnt_nxt = '0;
    end else if (last_c) begin
      cnt_nxt = '0;
      if (word_cnt != {WCNT_W{1'b1}}) begin
        wcnt_nxt = word_cnt + WCNT_W'(1);
      end
    end else begin
      cnt_nxt = bit_cnt + CNT_W'(1);
    end
    state_nxt = (cnt_nxt != '0) ? SHIFT : IDLE;
  end

endmodule

// File: rtl/spi_slave_shifter.sv
// Full-duplex SPI slave shift engine clocked by the SPI clock SLK and gated
// by active-high CS. Shifts tx_data out on MISO while assembling rx_data from
// MOSI; words may run back-to-back within one CS frame.
// Optional feature macro SPI_SLAVE_PARITY_EN: appends an even-parity bit to
// every word in both directions and adds the rx_perr output.
// Ports:
//   SLK, rst   : SPI clock (posedge) and async active-low reset
//   CS, MOSI   : chip select and serial input from the master
//   tx_data    : word to send, captured at the first bit of each word
//   MISO       : registered serial output
//   tx_load    : pulse, tx_data captured on this edge
//   rx_data    : last complete received word
//   rx_valid   : pulse, rx_data updated on this edge
//   busy       : word partially shifted
//   word_cnt   : completed words in this frame, saturating
//   rx_perr    : (parity build) received parity mismatch, updated with rx_valid
// even_parity() covers words up to PARITY_MAX_W bits.
module spi_slave_shifter #(
  parameter int unsigned DATA_W    = spi_slave_pkg::DEFAULT_DATA_W,
  parameter bit          LSB_FIRST = 1'b0,
  parameter int unsigned WCNT_W    = 8
) (
  input  logic              SLK,
  input  logic              rst,
  input  logic              CS,
  input  logic              MOSI,
  input  logic [DATA_W-1:0] tx_data,
  output logic              MISO,
  output logic              tx_load,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              busy,
  output logic [WCNT_W-1:0] word_cnt
`ifdef SPI_SLAVE_PARITY_EN
  ,
  output logic              rx_perr
`endif
);
  import spi_slave_pkg::*;

  localparam bit_order_e ORDER = LSB_FIRST ? spi_slave_pkg::LSB_FIRST
                                           : spi_slave_pkg::MSB_FIRST;
`ifdef SPI_SLAVE_PARITY_EN
  localparam int unsigned LEN = DATA_W + 1;
`else
  localparam int unsigned LEN = DATA_W;
`endif

  logic              first_c, last_c;
  logic [DATA_W-1:0] tx_sr, rx_sr;
  logic              tx_head_c, tx_nbit_c;
  logic [DATA_W-1:0] tx_rest_c, tx_adv_c, rx_shift_c;
`ifdef SPI_SLAVE_PARITY_EN
  logic              tx_par;
`endif

  spi_bit_counter #(
    .LEN    (LEN),
    .WCNT_W (WCNT_W)
  ) u_cnt (
    .clk      (SLK),
    .rst_n    (rst),
    .en       (CS),
    .first_c  (first_c),
    .last_c   (last_c),
    .busy     (busy),
    .word_cnt (word_cnt)
  );

  // Bit-order dependent taps and shifts for both directions.
  always_comb begin
    if (ORDER == spi_slave_pkg::LSB_FIRST) begin
      tx_head_c  = tx_data[0];
      tx_rest_c  = {1'b0, tx_data[DATA_W-1:1]};
      tx_nbit_c  = tx_sr[0];
      tx_adv_c   = {1'b0, tx_sr[DATA_W-1:1]};
      rx_shift_c = {MOSI, rx_sr[DATA_W-1:1]};
    end else begin
      tx_head_c  = tx_data[DATA_W-1];
      tx_rest_c  = {tx_data[DATA_W-2:0], 1'b0};
      tx_nbit_c  = tx_sr[DATA_W-1];
      tx_adv_c   = {tx_sr[DATA_W-2:0], 1'b0};
      rx_shift_c = {rx_sr[DATA_W-2:0], MOSI};
    end
  end

  // Shift datapath; CS low idles the wire but keeps the last rx_data.
  always_ff @(posedge SLK or negedge rst) begin
    if (!rst) begin
      MISO     <= 1'b0;
      tx_load  <= 1'b0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      tx_sr    <= '0;
      rx_sr    <= '0;
`ifdef SPI_SLAVE_PARITY_EN
      tx_par   <= 1'b0;
      rx_perr  <= 1'b0;
`endif
    end else if (!CS) begin
      MISO     <= 1'b0;
      tx_load  <= 1'b0;
      rx_valid <= 1'b0;
    end else begin
      tx_load  <= first_c;
      rx_valid <= last_c;

      if (first_c) begin
        MISO  <= tx_head_c;
        tx_sr <= tx_rest_c;
`ifdef SPI_SLAVE_PARITY_EN
        tx_par <= even_parity(PARITY_MAX_W'(tx_data));
`endif
      end
`ifdef SPI_SLAVE_PARITY_EN
      else if (last_c) begin
        MISO <= tx_par;
      end
`endif
      else begin
        MISO  <= tx_nbit_c;
        tx_sr <= tx_adv_c;
      end

`ifdef SPI_SLAVE_PARITY_EN
      // The trailing bit is parity: the data word is already complete in rx_sr.
      if (last_c) begin
        rx_data <= rx_sr;
        rx_perr <= MOSI ^ even_parity(PARITY_MAX_W'(rx_sr));
      end else begin
        rx_sr <= rx_shift_c;
      end
`else
      rx_sr <= rx_shift_c;
      if (last_c) begin
        rx_data <= rx_shift_c;
      end
`endif
    end
  end

endmodule

// File: tb/tb_spi_slave_shifter.sv
// Bench for spi_slave_shifter: an MSB-first and an LSB-first instance share
// all inputs; lsb_mode selects which one is observed. Expected MISO bits,
// received words and parity flags are queued as stimulus is driven and
// popped as the DUT produces them.
`timescale 1ns/1ps
module tb_spi_slave_shifter;

  localparam int unsigned DW = 16;
  localparam int unsigned WW = 8;
`ifdef SPI_SLAVE_PARITY_EN
  localparam int L = DW + 1;
`else
  localparam int L = DW;
`endif

  logic          SLK = 1'b0;
  logic          rst;
  logic          CS;
  logic          MOSI;
  logic [DW-1:0] tx_data;

  logic          m_miso, m_txl, m_rxv, m_busy;
  logic [DW-1:0] m_rxd;
  logic [WW-1:0] m_wcnt;
  logic          l_miso, l_txl, l_rxv, l_busy;
  logic [DW-1:0] l_rxd;
  logic [WW-1:0] l_wcnt;
`ifdef SPI_SLAVE_PARITY_EN
  logic          m_perr, l_perr;
`endif

  spi_slave_shifter #(.DATA_W(DW), .LSB_FIRST(1'b0), .WCNT_W(WW)) dut (
    .SLK(SLK), .rst(rst), .CS(CS), .MOSI(MOSI), .tx_data(tx_data),
    .MISO(m_miso), .tx_load(m_txl), .rx_data(m_rxd), .rx_valid(m_rxv),
    .busy(m_busy), .word_cnt(m_wcnt)
`ifdef SPI_SLAVE_PARITY_EN
    , .rx_perr(m_perr)
`endif
  );

  spi_slave_shifter #(.DATA_W(DW), .LSB_FIRST(1'b1), .WCNT_W(WW)) dut_lsb (
    .SLK(SLK), .rst(rst), .CS(CS), .MOSI(MOSI), .tx_data(tx_data),
    .MISO(l_miso), .tx_load(l_txl), .rx_data(l_rxd), .rx_valid(l_rxv),
    .busy(l_busy), .word_cnt(l_wcnt)
`ifdef SPI_SLAVE_PARITY_EN
    , .rx_perr(l_perr)
`endif
  );

  always #5 SLK = ~SLK;

  int      n_tests = 0;
  int      n_fail  = 0;
  logic    lsb_mode = 1'b0;
  logic    bad_par  = 1'b0;
  int      exp_wcnt = 0;

  logic          exp_miso_q[$];
  logic [DW-1:0] exp_rx_q[$];
  logic          exp_perr_q[$];

  logic          o_miso, o_txl, o_rxv, o_busy;
  logic [DW-1:0] o_rxd;
  logic [WW-1:0] o_wcnt;
  assign o_miso = lsb_mode ? l_miso : m_miso;
  assign o_txl  = lsb_mode ? l_txl  : m_txl;
  assign o_rxv  = lsb_mode ? l_rxv  : m_rxv;
  assign o_busy = lsb_mode ? l_busy : m_busy;
  assign o_rxd  = lsb_mode ? l_rxd  : m_rxd;
  assign o_wcnt = lsb_mode ? l_wcnt : m_wcnt;
`ifdef SPI_SLAVE_PARITY_EN
  logic o_perr;
  assign o_perr = lsb_mode ? l_perr : m_perr;
`endif

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One SLK edge: drive inputs, wait for the edge, compare 1ns later.
  // k is the bit position of this edge within the word (ignored when cs=0).
  task automatic tick(input logic cs, input logic mosi, input int k);
    logic eb;
    CS   = cs;
    MOSI = mosi;
    @(posedge SLK);
    #1;
    if (!cs) begin
      exp_wcnt = 0;
      chk("idle_miso",  32'(o_miso), 32'(0));
      chk("idle_txl",   32'(o_txl),  32'(0));
      chk("idle_rxv",   32'(o_rxv),  32'(0));
      chk("idle_busy",  32'(o_busy), 32'(0));
      chk("idle_wcnt",  32'(o_wcnt), 32'(0));
    end else begin
      if (exp_miso_q.size() == 0) begin
        chk("miso_q_empty", 32'(1), 32'(0));
      end else begin
        eb = exp_miso_q.pop_front();
        chk("miso", 32'(o_miso), 32'(eb));
      end
      chk("tx_load",  32'(o_txl),  32'(k == 0));
      chk("rx_valid", 32'(o_rxv),  32'(k == L - 1));
      chk("busy",     32'(o_busy), 32'(k != L - 1));
      if (k == L - 1 && exp_wcnt < 255) exp_wcnt++;
      chk("word_cnt", 32'(o_wcnt), 32'(exp_wcnt));
      if (o_rxv) begin
        if (exp_rx_q.size() == 0) begin
          chk("rx_q_empty", 32'(1), 32'(0));
        end else begin
          chk("rx_data", 32'(o_rxd), 32'(exp_rx_q.pop_front()));
        end
`ifdef SPI_SLAVE_PARITY_EN
        if (exp_perr_q.size() != 0) begin
          chk("rx_perr", 32'(o_perr), 32'(exp_perr_q.pop_front()));
        end
`endif
      end
    end
  endtask

  // Drive nbits of a word with CS high; a full word queues its expected rx.
  task automatic send_word(input logic [DW-1:0] tx, input logic [DW-1:0] rx, input int nbits);
    logic mb, wb;
    tx_data = tx;
    if (nbits == L) begin
      exp_rx_q.push_back(rx);
`ifdef SPI_SLAVE_PARITY_EN
      exp_perr_q.push_back(bad_par);
`endif
    end
    for (int i = 0; i < nbits; i++) begin
      if (i < int'(DW)) begin
        mb = lsb_mode ? tx[i] : tx[DW-1-i];
        wb = lsb_mode ? rx[i] : rx[DW-1-i];
      end else begin
        mb = ^tx;
        wb = (^rx) ^ bad_par;
      end
      exp_miso_q.push_back(mb);
      tick(1'b1, wb, i);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b0; CS = 1'b0; MOSI = 1'b0; tx_data = '0;
    #1;
    chk("rst_miso", 32'(m_miso), 32'(0));
    chk("rst_rxd",  32'(m_rxd),  32'(0));
    chk("rst_rxv",  32'(m_rxv),  32'(0));
    chk("rst_busy", 32'(m_busy), 32'(0));
    chk("rst_wcnt", 32'(m_wcnt), 32'(0));
    @(negedge SLK);
    rst = 1'b1;
    tick(1'b0, 1'b0, -1);

    // MSB-first word
    send_word(16'hA5C3, 16'h3C5A, L);
    tick(1'b0, 1'b0, -1);
    chk("t1_rx_hold", 32'(o_rxd), 32'h3C5A);

    // LSB-first word
    lsb_mode = 1'b1;
    send_word(16'h0001, 16'h0001, L);
    tick(1'b0, 1'b0, -1);
    chk("t2_rx_hold", 32'(o_rxd), 32'h0001);
    lsb_mode = 1'b0;

    // Partial word cut by CS drop, then a full word
    send_word(16'h5555, 16'hAAAA, 7);
    tick(1'b0, 1'b0, -1);
    send_word(16'h0F0F, 16'hFFFF, L);
    chk("t3_rxd",  32'(o_rxd),  32'hFFFF);
    chk("t3_wcnt", 32'(o_wcnt), 32'(1));
    tick(1'b0, 1'b0, -1);

    // Three back-to-back words in one frame
    send_word(16'h1111, 16'h1111, L);
    send_word(16'h2222, 16'h2222, L);
    send_word(16'h3333, 16'h3333, L);
    chk("t4_wcnt", 32'(o_wcnt), 32'(3));

    // Async reset mid-word (after 9 bits), between SLK edges
    send_word(16'hBEEF, 16'h1234, 9);
    #1 rst = 1'b0;
    #1;
    exp_wcnt = 0;
    chk("t5_miso", 32'(m_miso), 32'(0));
    chk("t5_txl",  32'(m_txl),  32'(0));
    chk("t5_rxd",  32'(m_rxd),  32'(0));
    chk("t5_rxv",  32'(m_rxv),  32'(0));
    chk("t5_busy", 32'(m_busy), 32'(0));
    chk("t5_wcnt", 32'(m_wcnt), 32'(0));
    chk("t5_lrxd", 32'(l_rxd),  32'(0));
    #1 rst = 1'b1;
    send_word(16'hC0DE, 16'h4321, L);
    tick(1'b0, 1'b0, -1);

`ifdef SPI_SLAVE_PARITY_EN
    // Parity: wrong then correct parity bit from the master
    bad_par = 1'b1;
    send_word(16'h0007, 16'h00F0, L);
    bad_par = 1'b0;
    send_word(16'h0007, 16'h00F1, L);
    tick(1'b0, 1'b0, -1);
`endif

    // Word counter saturation over a long frame
    for (int w = 0; w < 258; w++) begin
      send_word(DW'($urandom), DW'($urandom), L);
    end
    chk("sat_wcnt", 32'(o_wcnt), 32'(255));
    tick(1'b0, 1'b0, -1);

    chk("rx_q_drained",   32'(exp_rx_q.size()),   32'(0));
    chk("miso_q_drained", 32'(exp_miso_q.size()), 32'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
